bar_snapshot_scheduler: RTL and testbench
=========================================

// Module: bar_snapshot_scheduler
// PURPOSE
// Shares one single-port bar-height RAM between the spectrum updater (writes) and the display path.
// Once per frame, at the start of vertical blanking, it copies all bar heights into a shadow
// register file, so the picture never tears mid-frame.
// From the shadow file plus the VGA hc/vc counters it generates the 3/3/2 colour fed to the VGA timing block.
// PARAMETERS
// NUM_BARS  32   number of spectrum bars / RAM entries (power of 2)
// ADDR_W    5    log2(NUM_BARS)
// HEIGHT_W  9    bar height width, in lines
// BAR_W     20   pixel columns per bar (NUM_BARS*BAR_W == HPIXELS)
// HPIXELS   640  visible columns;  HTOTAL 800 total columns per line
// VPIXELS   480  visible lines
// FG_RGB    8'hFC  lit colour {r[2:0],g[2:0],b[1:0]};  BG_RGB 8'h00 unlit colour
// PORTS
// vgaclk      in   1         pixel clock, the same clock as the VGA timing block
// rst_n       in   1         reset, asynchronous, active-low
// hc          in   10        horizontal counter from the VGA timing block (hc_out)
// vc          in   10        vertical counter from the VGA timing block (vc_out)
// upd_valid   in   1         updater write request
// upd_ready   out  1         write accepted when upd_valid&&upd_ready at posedge
// upd_addr    in   ADDR_W    bar index to write
// upd_data    in   HEIGHT_W  new bar height
// mem_addr    out  ADDR_W    RAM address
// mem_we      out  1         RAM write enable
// mem_wdata   out  HEIGHT_W  RAM write data
// mem_rdata   in   HEIGHT_W  RAM read data, valid 1 cycle after the address
// snap_done   out  1         1-cycle pulse when the shadow copy completes
// pix_red     out  3         colour to the VGA input_red
// pix_green   out  3         colour to the VGA input_green
// pix_blue    out  2         colour to the VGA input_blue
// BEHAVIOUR
// Reset (async, rst_n=0):
// - state=IDLE; all shadow entries=0; column trackers=0.
// - snap_done=0, mem_we=0, mem_addr=0.
// - upd_ready=1 once rst_n=1 (follows IDLE).
// FSM IDLE -> FETCH -> DRAIN -> IDLE:
// - IDLE: upd_ready=1. A handshake drives mem_we=1, mem_addr=upd_addr, mem_wdata=upd_data in the same cycle.
// - Trigger is hc==0 && vc==VPIXELS. In the trigger cycle the FSM stays IDLE and still accepts a write;
//   FETCH starts in the next cycle, so that write is included in the snapshot.
// - FETCH: upd_ready=0, mem_we=0. Issues reads at addresses 0..NUM_BARS-1, one per cycle.
//   mem_rdata is captured into shadow[addr-1] on the following cycle.
// - After address NUM_BARS-1 is issued, go to DRAIN: capture shadow[NUM_BARS-1], pulse snap_done, return to IDLE.
// - FETCH+DRAIN = NUM_BARS+1 cycles (33), far shorter than vertical blanking; no display conflict.
// - upd_valid held during FETCH/DRAIN stalls, with no data loss. The updater must hold addr and data stable.
// - upd_addr >= NUM_BARS cannot occur (ADDR_W wide); every accepted write lands.
// - Reset mid-FETCH: the copy is aborted and the shadow is cleared; the next trigger reloads it.
// Column tracker (sequential, no divider): sub[4:0] and idx[ADDR_W-1:0] track the bar under hc.
// - If hc==HTOTAL-1: sub=0, idx=0.
// - Else if sub==BAR_W-1: sub=0, idx+=1.
// - Else sub+=1.
// - Saturate idx at NUM_BARS-1 in the blanking columns.
// Pixel (combinational from registers, zero latency vs hc/vc):
// - lit = hc<HPIXELS && vc<VPIXELS && (VPIXELS-1-vc) < shadow[idx].
// - {pix_red,pix_green,pix_blue} = lit ? FG_RGB : BG_RGB.
// - Compare in 10 bits, zero-extending height; a height >= VPIXELS lights the full column; height 0 lights nothing.
// Arithmetic: no wrap in the compare; idx never exceeds NUM_BARS-1.
// TESTING
// 1. Assert rst_n=0 for 3 cycles. Expect shadow=0, colour=BG for the whole frame, mem_we=0, and upd_ready=1 after release.
// 2. Write addr 3 = 100, run to the trigger and the next frame. Bar 3 (hc 60..79) is FG on vc 380..479 and BG on vc 379; other bars stay BG.
// 3. Hold upd_valid from trigger+1. Expect upd_ready=0 for 33 cycles, the write accepted on the cycle after snap_done, and the old value shown in that frame.
// 4. Write addr 31 = 7 in the trigger cycle itself. Expect it accepted and visible the next frame (hc 620..639, vc 473..479).
// 5. Drop rst_n at FETCH cycle 10. Expect state IDLE, colour BG, no snap_done; the next trigger's snapshot restores every bar.
// 6. Write height 511 to bar 0. Expect the full column FG (vc 0..479); height 0 gives all BG; snap_done is a single-cycle pulse per frame.

Source files
------------

// File: rtl/bar_snapshot_scheduler.sv
// Arbitrates the single-port bar-height RAM between updater writes and a once-per-frame
// shadow copy, and renders 3/3/2 bar-graph colour from the shadow file and hc/vc.
module bar_snapshot_scheduler #(
    parameter int            NUM_BARS = 32,
    parameter int            ADDR_W   = 5,
    parameter int            HEIGHT_W = 9,
    parameter int            BAR_W    = 20,
    parameter int            HPIXELS  = 640,
    parameter int            HTOTAL   = 800,
    parameter int            VPIXELS  = 480,
    parameter logic [7:0]    FG_RGB   = 8'hFC,
    parameter logic [7:0]    BG_RGB   = 8'h00
) (
    input  logic                vgaclk,
    input  logic                rst_n,
    input  logic [9:0]          hc,
    input  logic [9:0]          vc,
    input  logic                upd_valid,
    output logic                upd_ready,
    input  logic [ADDR_W-1:0]   upd_addr,
    input  logic [HEIGHT_W-1:0] upd_data,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [HEIGHT_W-1:0] mem_wdata,
    input  logic [HEIGHT_W-1:0] mem_rdata,
    output logic                snap_done,
    output logic [2:0]          pix_red,
    output logic [2:0]          pix_green,
    output logic [1:0]          pix_blue
);

    localparam int          SUB_W     = 5;
    localparam logic [9:0]  HPIX_C    = 10'(HPIXELS);
    localparam logic [9:0]  HLAST_C   = 10'(HTOTAL - 1);
    localparam logic [9:0]  VPIX_C    = 10'(VPIXELS);
    localparam logic [9:0]  VLAST_C   = 10'(VPIXELS - 1);
    localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(BAR_W - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_BARS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                state_reg, state_next;
    logic [ADDR_W-1:0]     fetch_addr_reg, fetch_addr_next;
    logic [HEIGHT_W-1:0]   shadow_reg [NUM_BARS];
    logic [SUB_W-1:0]      sub_reg;
    logic [ADDR_W-1:0]     idx_reg;
    logic                  trigger;
    logic                  capture_en;
    logic [ADDR_W-1:0]     capture_idx;

    assign trigger = (hc == 10'd0) && (vc == VPIX_C);

    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            fetch_addr_reg <= '0;
        end else begin
            state_reg      <= state_next;
            fetch_addr_reg <= fetch_addr_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        fetch_addr_next = fetch_addr_reg;
        upd_ready       = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wdata       = upd_data;
        snap_done       = 1'b0;
        case (state_reg)
            IDLE: begin
                upd_ready = 1'b1;
                if (upd_valid) begin
                    mem_we   = 1'b1;
                    mem_addr = upd_addr;
                end
                // The write accepted in the trigger cycle lands before address 0 is read.
                if (trigger) begin
                    state_next      = FETCH;
                    fetch_addr_next = '0;
                end
            end
            FETCH: begin
                mem_addr = fetch_addr_reg;
                if (fetch_addr_reg == IDX_LAST) begin
                    state_next = DRAIN;
                end else begin
                    fetch_addr_next = fetch_addr_reg + 1'b1;
                end
            end
            DRAIN: begin
                snap_done  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Read data always belongs to the address issued one cycle earlier.
    assign capture_en  = ((state_reg == FETCH) && (fetch_addr_reg != '0)) || (state_reg == DRAIN);
    assign capture_idx = (state_reg == DRAIN) ? IDX_LAST : fetch_addr_reg - 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_BARS; gi++) begin : g_shadow
            always_ff @(posedge vgaclk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_reg[gi] <= '0;
                end else if (capture_en && (capture_idx == ADDR_W'(gi))) begin
                    shadow_reg[gi] <= mem_rdata;
                end
            end
        end
    endgenerate

    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            sub_reg <= '0;
            idx_reg <= '0;
        end else if (hc == HLAST_C) begin
            sub_reg <= '0;
            idx_reg <= '0;
        end else if (sub_reg == SUB_LAST) begin
            sub_reg <= '0;
            if (idx_reg != IDX_LAST) begin
                idx_reg <= idx_reg + 1'b1;
            end
        end else begin
            sub_reg <= sub_reg + 1'b1;
        end
    end

    logic [9:0] height_ext;
    logic       lit;
    logic [7:0] colour;

    assign height_ext = 10'(shadow_reg[idx_reg]);
    // vc < VPIXELS is checked alongside, so the subtraction never wraps when it matters.
    assign lit    = (hc < HPIX_C) && (vc < VPIX_C) && ((VLAST_C - vc) < height_ext);
    assign colour = lit ? FG_RGB : BG_RGB;
    assign {pix_red, pix_green, pix_blue} = colour;

endmodule

// File: tb/tb_bar_snapshot_scheduler.sv
// Directed bench for bar_snapshot_scheduler: drives hc/vc line by line, models the
// single-port RAM, and checks handshakes, snapshot timing and every pixel of chosen lines.
module tb_bar_snapshot_scheduler;

    logic       vgaclk = 1'b0;
    logic       rst_n  = 1'b0;
    logic [9:0] hc     = 10'd799;
    logic [9:0] vc     = 10'd524;
    logic       upd_valid = 1'b0;
    logic       upd_ready;
    logic [4:0] upd_addr = '0;
    logic [8:0] upd_data = '0;
    logic [4:0] mem_addr;
    logic       mem_we;
    logic [8:0] mem_wdata;
    logic [8:0] mem_rdata = '0;
    logic       snap_done;
    logic [2:0] pix_red;
    logic [2:0] pix_green;
    logic [1:0] pix_blue;

    logic [8:0] ram [32] = '{default: 9'd0};

    int n_vec = 0;
    int n_err = 0;
    int exp_h [32];
    int acc_hc, snap_cnt, snap_hc, nready;

    bar_snapshot_scheduler dut (
        .vgaclk    (vgaclk),
        .rst_n     (rst_n),
        .hc        (hc),
        .vc        (vc),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .upd_addr  (upd_addr),
        .upd_data  (upd_data),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .snap_done (snap_done),
        .pix_red   (pix_red),
        .pix_green (pix_green),
        .pix_blue  (pix_blue)
    );

    always #5 vgaclk = ~vgaclk;

    always @(posedge vgaclk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_pix(input int h, input int v);
        if (h < 640 && v < 480 && (479 - v) < exp_h[h / 20]) return 8'hFC;
        return 8'h00;
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        hc        = 10'd799;
        vc        = 10'd524;
        upd_valid = 1'b0;
        repeat (3) begin
            @(negedge vgaclk);
            check("rst_mem_we", 32'(mem_we), 0);
            check("rst_mem_addr", 32'(mem_addr), 0);
            check("rst_snap_done", 32'(snap_done), 0);
            check("rst_pix", 32'({pix_red, pix_green, pix_blue}), 0);
        end
        @(posedge vgaclk);
        #1 rst_n = 1'b1;
        @(negedge vgaclk);
        check("rst_upd_ready", 32'(upd_ready), 1);
        for (int i = 0; i < 32; i++) exp_h[i] = 0;
        $display("reset applied");
    endtask

    // One full scan line; optional write request raised at hc == wr_hc and held until accepted.
    task automatic run_line(input int v, input int wr_hc, input int wa, input int wd);
        acc_hc   = -1;
        snap_cnt = 0;
        snap_hc  = -1;
        nready   = 0;
        for (int h = 0; h < 800; h++) begin
            @(posedge vgaclk);
            #1;
            hc = 10'(h);
            vc = 10'(v);
            if (acc_hc >= 0) upd_valid = 1'b0;
            if (h == wr_hc) begin
                upd_valid = 1'b1;
                upd_addr  = 5'(wa);
                upd_data  = 9'(wd);
            end
            @(negedge vgaclk);
            check($sformatf("pix h%0d v%0d", h, v), 32'({pix_red, pix_green, pix_blue}), 32'(exp_pix(h, v)));
            if (!upd_ready) begin
                nready++;
                check("stall_we", 32'(mem_we), 0);
            end
            if (snap_done) begin
                snap_cnt++;
                snap_hc = h;
            end
            if (upd_valid && upd_ready && acc_hc < 0) begin
                acc_hc = h;
                check("wr_we", 32'(mem_we), 1);
                check("wr_addr", 32'(mem_addr), 32'(wa));
                check("wr_data", 32'(mem_wdata), 32'(wd));
            end
        end
        upd_valid = 1'b0;
        $display("line vc=%0d acc_hc=%0d snaps=%0d snap_hc=%0d stalled=%0d", v, acc_hc, snap_cnt, snap_hc, nready);
    endtask

    task automatic run_trigger(input int wr_hc, input int wa, input int wd);
        run_line(480, wr_hc, wa, wd);
        check("snap_cnt", 32'(snap_cnt), 1);
        check("snap_hc", 32'(snap_hc), 33);
        check("stall_cycles", 32'(nready), 33);
    endtask

    initial begin
        // Reset and an empty picture
        do_reset();
        run_line(0, -1, 0, 0);
        run_line(240, -1, 0, 0);
        run_line(479, -1, 0, 0);

        // Bar 3 = 100 becomes visible on the next frame
        run_line(0, 100, 3, 100);
        check("t2_acc", 32'(acc_hc), 100);
        run_trigger(-1, 0, 0);
        exp_h[3] = 100;
        run_line(379, -1, 0, 0);
        run_line(380, -1, 0, 0);
        run_line(479, -1, 0, 0);

        // Write held from trigger+1 stalls through the copy and misses this snapshot
        run_trigger(1, 5, 50);
        check("t3_acc", 32'(acc_hc), 34);
        run_line(479, -1, 0, 0);
        run_trigger(-1, 0, 0);
        exp_h[5] = 50;
        run_line(430, -1, 0, 0);
        run_line(429, -1, 0, 0);

        // Write in the trigger cycle itself is part of the snapshot
        run_trigger(0, 31, 7);
        check("t4_acc", 32'(acc_hc), 0);
        exp_h[31] = 7;
        run_line(473, -1, 0, 0);
        run_line(472, -1, 0, 0);

        // Reset at FETCH cycle 10 aborts the copy
        for (int h = 0; h <= 10; h++) begin
            @(posedge vgaclk);
            #1;
            hc = 10'(h);
            vc = 10'd480;
            if (h == 10) rst_n = 1'b0;
        end
        @(negedge vgaclk);
        check("t5_snap_done", 32'(snap_done), 0);
        check("t5_mem_we", 32'(mem_we), 0);
        check("t5_mem_addr", 32'(mem_addr), 0);
        check("t5_idle", 32'(upd_ready), 1);
        do_reset();
        run_line(479, -1, 0, 0);
        run_trigger(-1, 0, 0);
        exp_h[3]  = 100;
        exp_h[5]  = 50;
        exp_h[31] = 7;
        run_line(479, -1, 0, 0);
        run_line(380, -1, 0, 0);

        // Height 511 lights the whole column; height 0 lights nothing
        run_line(100, 50, 0, 511);
        check("t6_acc", 32'(acc_hc), 50);
        run_trigger(-1, 0, 0);
        exp_h[0] = 511;
        run_line(0, -1, 0, 0);
        run_line(479, -1, 0, 0);
        run_line(200, 7, 0, 0);
        check("t6_acc0", 32'(acc_hc), 7);
        run_trigger(-1, 0, 0);
        exp_h[0] = 0;
        run_line(479, -1, 0, 0);
        run_line(0, -1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
